mat_mul: RTL and testbench
==========================

Name: mat_mul

Overview:
- Computes the Ising-style quadratic energy E = s^T·J·s, where s is a ±1 spin vector derived from a bit vector sigma and J is an N×N unsigned matrix.
- J is streamed from memory a few columns per clock. The block requests chunk indices and accumulates a signed running energy.
- Sits between the J-matrix memory and the annealing control loop. It reports the final energy and whether it improved on the previous energy.

Parameters:
- MEM_BANDWIDTH, 4096: bits of J delivered per read.
- VECTOR_SIZE, 256: N, number of spins and the J dimension.
- J_ELEMENT_WIDTH, 4: unsigned width of each J element.
- J_COLS_PER_READ (localparam), MEM_BANDWIDTH/(VECTOR_SIZE*J_ELEMENT_WIDTH) = 4: columns per chunk.
- NUM_J_CHUNKS (localparam), VECTOR_SIZE/J_COLS_PER_READ = 64: chunks per run.
- INT_RESULT_WIDTH (localparam), $clog2(VECTOR_SIZE)+J_ELEMENT_WIDTH+1 = 13: signed column dot-product width.
- ENERGY_WIDTH (localparam), J_ELEMENT_WIDTH+2*$clog2(VECTOR_SIZE)+1 = 21: signed energy width.
- PIPE_DEPTH (localparam), 2: pipeline stages between chunk sampling and energy accumulation.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-high reset (asserted when 1, sampled on clk).
- start  in  1  run request, single-cycle pulse.
- sigma  in  VECTOR_SIZE  spin bits: 1 → s=+1 (add), 0 → s=−1 (subtract).
- J_Matrix_chunk  in  unpacked [0:VECTOR_SIZE-1][0:J_COLS_PER_READ-1] × J_ELEMENT_WIDTH  J rows for the columns of the current chunk.
- Energy_previous  in  ENERGY_WIDTH  previous energy; all-ones is the "none" sentinel.
- chunk_idx  out  $clog2(NUM_J_CHUNKS)  chunk being requested; columns chunk_idx*J_COLS_PER_READ+c.
- start_enable  out  1  busy flag.
- Energy_next  out  ENERGY_WIDTH  signed running/final energy.
- done  out  1  one-cycle pulse when the run completes.
- improved  out  1  final energy is better than Energy_previous.

Behaviour:
- Reset values: start_enable=0, done=0, improved=0, chunk_idx=0, Energy_next=0, all pipeline registers cleared. Reset mid-run aborts to idle with the same values.
- Idle: when start=1 at a posedge, on that edge:
  - latch sigma into an internal register;
  - clear Energy_next to 0;
  - set start_enable=1 and chunk_idx=0.
- start while start_enable=1 is ignored. sigma changes during a run have no effect.
- Issue phase: for NUM_J_CHUNKS cycles, chunk_idx increments by 1 per cycle. J_Matrix_chunk must hold the data for the current chunk_idx in the same cycle (combinational memory read) and is registered on that edge.
- Stage 1: for each column c, dot_c = Σ_i s_i·J[i][c]. Computed as a signed adder tree, sign-extended to INT_RESULT_WIDTH, with no overflow possible.
- Stage 2: chunk term = Σ_c s_col·dot_c, where s_col is the latched sigma bit of the absolute column index. Energy_next += chunk term.
- Energy_next is signed two's-complement in ENERGY_WIDTH; the maximum |E| = N²·15 = 983040 fits. Intermediate partial sums may be negative.
- start_enable stays high for exactly NUM_J_CHUNKS+PIPE_DEPTH = 66 cycles, until the last chunk term has been accumulated.
- On the edge where start_enable falls:
  - done pulses for one cycle;
  - Energy_next holds the final E;
  - improved is computed.
- Energy_next and improved then hold until the next start or reset.
- improved = 1 if Energy_previous is all-ones; otherwise improved = (signed Energy_next < signed Energy_previous).
- A new start is accepted the cycle after start_enable falls.

Test Plan:
- sigma all 0, J≡1: run → start_enable high 66 cycles; final Energy_next = (−256)²·1 = 65536; done pulses once; improved=1 with Energy_previous all-ones.
- sigma all 1, J≡1 → Energy_next = 65536. sigma alternating 1010… (bit0=1), J≡1 → Energy_next = 0.
- J≡15 with sigma all0 / all1 / alternating → Energy_next = 983040 / 983040 / 0 (no overflow at 21 bits).
- Energy_previous = 70000, sigma with 192 ones, J≡1 → E = (2·192−256)² = 16384; improved=1. Rerun with Energy_previous = 1000 → improved=0.
- start pulsed again mid-run and sigma changed mid-run → ignored; result unchanged, still 66 busy cycles. chunk_idx counts 0..63 once per run.
- rst_n asserted at cycle 30 of a run → next cycle start_enable=0, Energy_next=0, chunk_idx=0, no done pulse. A subsequent run gives the correct result.

Source files
------------

// File: rtl/mat_mul.sv
// Streams J a chunk of columns per cycle and accumulates the signed Ising energy s^T*J*s for a latched spin vector.
// Latency: busy for NUM_J_CHUNKS+PIPE_DEPTH cycles after start; done pulses on the cycle busy drops.
// No backpressure: J must be valid combinationally for chunk_idx every issue cycle; start is ignored while busy.
module mat_mul #(
    parameter  int MEM_BANDWIDTH    = 4096,
    parameter  int VECTOR_SIZE      = 256,
    parameter  int J_ELEMENT_WIDTH  = 4,
    localparam int J_COLS_PER_READ  = MEM_BANDWIDTH / (VECTOR_SIZE * J_ELEMENT_WIDTH),
    localparam int NUM_J_CHUNKS     = VECTOR_SIZE / J_COLS_PER_READ,
    localparam int INT_RESULT_WIDTH = $clog2(VECTOR_SIZE) + J_ELEMENT_WIDTH + 1,
    localparam int ENERGY_WIDTH     = J_ELEMENT_WIDTH + 2 * $clog2(VECTOR_SIZE) + 1,
    localparam int PIPE_DEPTH       = 2,
    localparam int CHUNK_W          = $clog2(NUM_J_CHUNKS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [VECTOR_SIZE-1:0]     sigma,
    input  logic [J_ELEMENT_WIDTH-1:0] J_Matrix_chunk [0:VECTOR_SIZE-1][0:J_COLS_PER_READ-1],
    input  logic [ENERGY_WIDTH-1:0]    Energy_previous,
    output logic [CHUNK_W-1:0]         chunk_idx,
    output logic                       start_enable,
    output logic [ENERGY_WIDTH-1:0]    Energy_next,
    output logic                       done,
    output logic                       improved
);
    localparam int IDX_W      = $clog2(VECTOR_SIZE);
    localparam int RUN_CYCLES = NUM_J_CHUNKS + PIPE_DEPTH;
    localparam int CNT_W      = $clog2(RUN_CYCLES + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                             state, state_nxt;
    logic [CNT_W-1:0]                   cnt;
    logic                               issue;
    logic                               last_cyc;
    logic                               accept;
    logic [VECTOR_SIZE-1:0]             sigma_q;
    logic [J_ELEMENT_WIDTH-1:0]         chunk_q [0:VECTOR_SIZE-1][0:J_COLS_PER_READ-1];
    logic                               v1, v2;
    logic [IDX_W-1:0]                   base1, base2;
    logic signed [INT_RESULT_WIDTH-1:0] dot   [0:J_COLS_PER_READ-1];
    logic signed [INT_RESULT_WIDTH-1:0] dot_q [0:J_COLS_PER_READ-1];
    logic signed [ENERGY_WIDTH-1:0]     term;
    logic signed [ENERGY_WIDTH-1:0]     energy_sum;

    assign start_enable = (state == S_RUN);
    assign accept       = (state == S_IDLE) && start;

    // State register: reset aborts any run back to idle.
    always_ff @(posedge clk) begin
        if (rst_n) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state plus issue/last strobes derived from the run cycle counter.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        last_cyc  = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_RUN;
            S_RUN: begin
                issue = (cnt < CNT_W'(NUM_J_CHUNKS));
                if (cnt == CNT_W'(RUN_CYCLES - 1)) begin
                    last_cyc  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Run counter, chunk request index and the spin vector frozen for the whole run.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt       <= '0;
            chunk_idx <= '0;
            sigma_q   <= '0;
        end else if (accept) begin
            cnt       <= '0;
            chunk_idx <= '0;
            sigma_q   <= sigma;
        end else if (state == S_RUN) begin
            cnt <= last_cyc ? '0 : cnt + 1'b1;
            if (issue) chunk_idx <= chunk_idx + 1'b1;
        end
    end

    // Capture the chunk returned for the current chunk_idx together with its first column index.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            v1    <= 1'b0;
            base1 <= '0;
            for (int i = 0; i < VECTOR_SIZE; i++)
                for (int c = 0; c < J_COLS_PER_READ; c++)
                    chunk_q[i][c] <= '0;
        end else begin
            v1 <= issue;
            if (issue) begin
                base1   <= IDX_W'(chunk_idx * J_COLS_PER_READ);
                chunk_q <= J_Matrix_chunk;
            end
        end
    end

    // Per-column signed dot product s.J[:,c]; width covers N*max(J) so it cannot overflow.
    always_comb begin
        for (int c = 0; c < J_COLS_PER_READ; c++) begin
            dot[c] = '0;
            for (int i = 0; i < VECTOR_SIZE; i++) begin
                if (sigma_q[i]) dot[c] = dot[c] + $signed(INT_RESULT_WIDTH'(chunk_q[i][c]));
                else            dot[c] = dot[c] - $signed(INT_RESULT_WIDTH'(chunk_q[i][c]));
            end
        end
    end

    // Register the column dot products for the accumulation stage.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            v2    <= 1'b0;
            base2 <= '0;
            for (int c = 0; c < J_COLS_PER_READ; c++) dot_q[c] <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                base2 <= base1;
                dot_q <= dot;
            end
        end
    end

    // Chunk term: each column's dot product weighted by the spin of that absolute column.
    always_comb begin
        term = '0;
        for (int c = 0; c < J_COLS_PER_READ; c++) begin
            if (sigma_q[base2 + IDX_W'(c)]) term = term + ENERGY_WIDTH'(dot_q[c]);
            else                            term = term - ENERGY_WIDTH'(dot_q[c]);
        end
        energy_sum = $signed(Energy_next) + term;
    end

    // Energy accumulation, completion pulse and comparison against the previous energy.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            Energy_next <= '0;
            done        <= 1'b0;
            improved    <= 1'b0;
        end else begin
            done <= last_cyc;
            if (accept) begin
                Energy_next <= '0;
                improved    <= 1'b0;
            end else if (v2) begin
                Energy_next <= energy_sum;
            end
            if (last_cyc)
                improved <= (&Energy_previous) || (energy_sum < $signed(Energy_previous));
        end
    end

endmodule

// File: tb/tb_mat_mul.sv
// Directed bench for mat_mul: hand-computed energies for constant and single-column J patterns.
// Checks busy length, chunk_idx sequence, done pulse, energy, improved, and mid-run start/sigma/reset.
// J is presented combinationally from chunk_idx, modelling a zero-latency memory.
module tb_mat_mul;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [255:0] sigma;
    logic [3:0]  J [0:255][0:3];
    logic [20:0] Energy_previous;
    logic [5:0]  chunk_idx;
    logic        start_enable;
    logic [20:0] Energy_next;
    logic        done;
    logic        improved;

    int          jmode;
    logic [3:0]  jval;
    int          tcol;
    int          checks   = 0;
    int          failures = 0;

    mat_mul dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .sigma          (sigma),
        .J_Matrix_chunk (J),
        .Energy_previous(Energy_previous),
        .chunk_idx      (chunk_idx),
        .start_enable   (start_enable),
        .Energy_next    (Energy_next),
        .done           (done),
        .improved       (improved)
    );

    always #5 clk = ~clk;

    // Memory model: mode 0 fills J with jval, mode 1 only fills absolute column tcol.
    always_comb begin
        for (int i = 0; i < 256; i++)
            for (int c = 0; c < 4; c++)
                J[i][c] = (jmode == 0 || (int'(chunk_idx) * 4 + c) == tcol) ? jval : 4'd0;
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_case(input string tag, input logic [255:0] sig, input int jm,
                            input logic [3:0] jv, input int tc, input logic [20:0] prev,
                            input longint exp_e, input logic exp_imp, input bit disturb);
        int busy;
        int idx_err;
        int early_done;
        @(negedge clk);
        sigma = sig; jmode = jm; jval = jv; tcol = tc; Energy_previous = prev; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy = 0; idx_err = 0; early_done = 0;
        while (start_enable && busy < 200) begin
            if (done) early_done++;
            if (busy < 64 && chunk_idx != 6'(busy)) idx_err++;
            if (disturb && busy == 10) begin start = 1'b1; sigma = ~sig; end
            if (disturb && busy == 11) start = 1'b0;
            busy++;
            @(negedge clk);
        end
        chk({tag, ".busy"}, busy, 66);
        chk({tag, ".idx"}, idx_err, 0);
        chk({tag, ".early_done"}, early_done, 0);
        chk({tag, ".done"}, done, 1);
        chk({tag, ".energy"}, $signed(Energy_next), exp_e);
        chk({tag, ".improved"}, improved, exp_imp);
        @(negedge clk);
        chk({tag, ".done_clr"}, done, 0);
        chk({tag, ".hold"}, $signed(Energy_next), exp_e);
    endtask

    initial begin
        logic [255:0] s0, s1, salt, s192;
        int busy;
        int dones;
        s0   = '0;
        s1   = '1;
        salt = {128{2'b01}};
        s192 = {64'd0, {192{1'b1}}};
        rst_n = 1'b1; start = 1'b0; sigma = '0; Energy_previous = '1;
        jmode = 0; jval = 4'd1; tcol = 0;
        repeat (3) @(negedge clk);
        chk("rst.start_enable", start_enable, 0);
        chk("rst.done", done, 0);
        chk("rst.improved", improved, 0);
        chk("rst.chunk_idx", chunk_idx, 0);
        chk("rst.energy", Energy_next, 0);
        rst_n = 1'b0;

        run_case("s0_j1",   s0,   0, 4'd1,  0, '1, 65536, 1'b1, 1'b0);
        run_case("s1_j1",   s1,   0, 4'd1,  0, '1, 65536, 1'b1, 1'b0);
        run_case("alt_j1",  salt, 0, 4'd1,  0, '1, 0,     1'b1, 1'b0);
        run_case("s0_j15",  s0,   0, 4'd15, 0, '1, 983040, 1'b1, 1'b0);
        run_case("s1_j15",  s1,   0, 4'd15, 0, '1, 983040, 1'b1, 1'b0);
        run_case("alt_j15", salt, 0, 4'd15, 0, '1, 0,     1'b1, 1'b0);
        run_case("s192_p70000", s192, 0, 4'd1, 0, 21'd70000, 16384, 1'b1, 1'b0);
        run_case("s192_p1000",  s192, 0, 4'd1, 0, 21'd1000,  16384, 1'b0, 1'b0);
        run_case("col0",   s192, 1, 4'd1, 0,   21'd0,   128,  1'b0, 1'b0);
        run_case("col255", s192, 1, 4'd1, 255, 21'd0,   -128, 1'b1, 1'b0);
        run_case("col130_eq", s192, 1, 4'd7, 130, 21'd896, 896, 1'b0, 1'b0);
        run_case("disturb", s0, 0, 4'd1, 0, 21'd1000, 65536, 1'b0, 1'b1);

        // Reset asserted in the middle of a run.
        @(negedge clk);
        sigma = s0; jmode = 0; jval = 4'd1; Energy_previous = '1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy = 0;
        while (start_enable && busy < 30) begin
            busy++;
            @(negedge clk);
        end
        chk("midrst.reached", busy, 30);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        chk("midrst.start_enable", start_enable, 0);
        chk("midrst.energy", Energy_next, 0);
        chk("midrst.chunk_idx", chunk_idx, 0);
        chk("midrst.done", done, 0);
        dones = 0;
        for (int k = 0; k < 80; k++) begin
            if (done || start_enable) dones++;
            @(negedge clk);
        end
        chk("midrst.quiet", dones, 0);
        run_case("after_rst", s1, 0, 4'd15, 0, '1, 983040, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
